// File: rtl/countdown_pkg.sv
// Shared types for the countdown controller: FSM state encoding.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } cd_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the board clock into one-cycle count ticks; holds its value while en is low.
module tick_prescaler #(
    parameter int unsigned DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PW = $clog2(DIV) + 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    // With DIV==1 the counter is pinned at 0, so tick follows en directly.
    assign tick = en && (presc_q == LAST);

    always_comb begin
        presc_d = presc_q;
        if (clr) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = (presc_q == LAST) ? '0 : presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/countdown_ctrl.sv
// Run/pause/expire sequencer and count register for the 7-seg countdown display.
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int unsigned N           = 4,
    parameter int unsigned DIV         = 50_000_000,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic         pause_i,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [N-1:0] load_val_i,
    output logic [N-1:0] count_o,
    output logic         running_o,
    output logic         paused_o,
    output logic         done_o,
    output logic         expire_o
);

    cd_state_t    state_q, state_d;
    logic [N-1:0] count_q, count_d;
    logic [N-1:0] reload_q, reload_d;
    logic         evt_q, evt_d;
    logic         expire_q;
    logic         running_q, running_d;
    logic         paused_q, paused_d;
    logic         done_q, done_d;
    logic         presc_en;
    logic         presc_clr;
    logic         tick;

    // A pause request freezes the prescaler on the very cycle it is seen.
    assign presc_en = (state_q == RUN) && !pause_i;

    tick_prescaler #(
        .DIV (DIV)
    ) u_presc (
        .clk   (clk),
        .reset (reset),
        .en    (presc_en),
        .clr   (presc_clr),
        .tick  (tick)
    );

    // Next-state and datapath update; priority clear > load > pause > start.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        evt_d     = 1'b0;
        presc_clr = 1'b0;

        if (clear_i) begin
            state_d   = IDLE;
            count_d   = reload_q;
            presc_clr = 1'b1;
        end else if (load_i && (state_q != RUN)) begin
            reload_d = load_val_i;
            count_d  = load_val_i;
            if (state_q == DONE) begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (count_q == '0) begin
                            state_d = DONE;
                            evt_d   = 1'b1;
                        end else begin
                            state_d   = RUN;
                            presc_clr = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pause_i) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        if (count_q > N'(1)) begin
                            count_d = count_q - N'(1);
                        end else if (count_q == N'(1)) begin
                            count_d = '0;
                            evt_d   = 1'b1;
                            if (!AUTO_RELOAD) begin
                                state_d = DONE;
                            end
                        end else begin
                            // Only reachable with auto-reload: the zero period ends here.
                            count_d = reload_q;
                            evt_d   = (reload_q == '0);
                        end
                    end
                end
                PAUSE: begin
                    if (start_i) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    if (start_i) begin
                        count_d = reload_q;
                        if (reload_q == '0) begin
                            evt_d = 1'b1;
                        end else begin
                            state_d   = RUN;
                            presc_clr = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Status flags are registered from the next state so they align with state_q.
    always_comb begin
        running_d = (state_d == RUN);
        paused_d  = (state_d == PAUSE);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= '1;
            reload_q  <= '1;
            evt_q     <= 1'b0;
            expire_q  <= 1'b0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            evt_q     <= evt_d;
            expire_q  <= evt_q;
            running_q <= running_d;
            paused_q  <= paused_d;
            done_q    <= done_d;
        end
    end

    assign count_o   = count_q;
    assign running_o = running_q;
    assign paused_o  = paused_q;
    assign done_o    = done_q;
    assign expire_o  = expire_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Scoreboard bench for countdown_ctrl: a one-shot N=4 instance and an auto-reload N=2 instance.
module tb_countdown_ctrl;

    localparam int DIV     = 4;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    typedef struct {
        int st;
        int cnt;
        int rel;
        int presc;
        bit evt;
        bit exp;
    } m_t;

    logic       clk;
    logic       reset;
    logic       start, pause, clear, load;
    logic [3:0] ld_val;

    logic [3:0] cnt_a;
    logic       run_a, pau_a, done_a, exp_a;
    logic [1:0] cnt_b;
    logic       run_b, pau_b, done_b, exp_b;

    logic [15:0] obs_a, obs_b;
    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    m_t          ma, mb;
    int          n_vec = 0;
    int          n_bad = 0;

    countdown_ctrl #(.N(4), .DIV(DIV), .AUTO_RELOAD(1'b0)) dut_a (
        .clk(clk), .reset(reset), .start_i(start), .pause_i(pause), .clear_i(clear),
        .load_i(load), .load_val_i(ld_val), .count_o(cnt_a), .running_o(run_a),
        .paused_o(pau_a), .done_o(done_a), .expire_o(exp_a)
    );

    countdown_ctrl #(.N(2), .DIV(DIV), .AUTO_RELOAD(1'b1)) dut_b (
        .clk(clk), .reset(reset), .start_i(start), .pause_i(pause), .clear_i(clear),
        .load_i(load), .load_val_i(ld_val[1:0]), .count_o(cnt_b), .running_o(run_b),
        .paused_o(pau_b), .done_o(done_b), .expire_o(exp_b)
    );

    assign obs_a = {8'b0, cnt_a, run_a, pau_a, done_a, exp_a};
    assign obs_b = {10'b0, cnt_b, run_b, pau_b, done_b, exp_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic m_t mreset(input int n);
        m_t m;
        m.st    = S_IDLE;
        m.cnt   = (1 << n) - 1;
        m.rel   = (1 << n) - 1;
        m.presc = 0;
        m.evt   = 1'b0;
        m.exp   = 1'b0;
        return m;
    endfunction

    function automatic logic [15:0] expv(input m_t m);
        int v;
        v = (m.cnt << 4) | ((m.st == S_RUN) ? 8 : 0) | ((m.st == S_PAUSE) ? 4 : 0)
            | ((m.st == S_DONE) ? 2 : 0) | (m.exp ? 1 : 0);
        return 16'(v);
    endfunction

    // Behavioural reference for one clock edge.
    function automatic m_t step(input m_t m, input bit s, input bit p, input bit c,
                                input bit l, input int v, input int n, input bit ar);
        m_t x;
        bit tk;
        int mask;
        x    = m;
        mask = (1 << n) - 1;
        tk   = (m.st == S_RUN) && (m.presc == DIV - 1);
        x.evt = 1'b0;
        x.exp = m.evt;
        if (m.st == S_RUN && !p) x.presc = tk ? 0 : m.presc + 1;
        if (c) begin
            x.st = S_IDLE; x.cnt = m.rel; x.presc = 0;
        end else if (l && m.st != S_RUN) begin
            x.rel = v & mask; x.cnt = v & mask;
            if (m.st == S_DONE) x.st = S_IDLE;
        end else begin
            case (m.st)
                S_IDLE: if (s) begin
                    if (m.cnt == 0) begin x.st = S_DONE; x.evt = 1'b1; end
                    else begin x.st = S_RUN; x.presc = 0; end
                end
                S_RUN: if (p) x.st = S_PAUSE;
                    else if (tk) begin
                        if (m.cnt > 1) x.cnt = m.cnt - 1;
                        else if (m.cnt == 1) begin
                            x.cnt = 0; x.evt = 1'b1;
                            if (!ar) x.st = S_DONE;
                        end else begin
                            x.cnt = m.rel; x.evt = (m.rel == 0);
                        end
                    end
                S_PAUSE: if (s) x.st = S_RUN;
                default: if (s) begin
                    x.cnt = m.rel;
                    if (m.rel == 0) x.evt = 1'b1;
                    else begin x.st = S_RUN; x.presc = 0; end
                end
            endcase
        end
        return x;
    endfunction

    task automatic cyc(input bit s, input bit p, input bit c, input bit l, input logic [3:0] v);
        start = s; pause = p; clear = c; load = l; ld_val = v;
        ma = step(ma, s, p, c, l, int'(v), 4, 1'b0);
        mb = step(mb, s, p, c, l, int'(v), 2, 1'b1);
        q_a.push_back(expv(ma));
        q_b.push_back(expv(mb));
        @(posedge clk);
        #1;
        chk("sb_a", obs_a, q_a.pop_front());
        chk("sb_b", obs_b, q_b.pop_front());
        start = 1'b0; pause = 1'b0; clear = 1'b0; load = 1'b0; ld_val = 4'd0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 4'd0);
    endtask

    initial begin
        int chg_v[8];
        int chg_t[8];
        int nchg, nexp, texp, hit, bad_run;
        logic [3:0] prev;

        reset = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0; load = 1'b0; ld_val = 4'd0;
        ma = mreset(4);
        mb = mreset(2);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a", obs_a, 16'h00F0);
        chk("rst_b", obs_b, 16'h0030);
        reset = 1'b1;

        // Load 3 and count down to DONE.
        cyc(0, 0, 0, 1, 4'd3);
        cyc(1, 0, 0, 0, 4'd0);
        nchg = 0; nexp = 0; texp = 0; prev = cnt_a;
        for (int k = 1; k <= 32; k++) begin
            cyc(0, 0, 0, 0, 4'd0);
            if (cnt_a != prev && nchg < 8) begin
                chg_v[nchg] = int'(cnt_a); chg_t[nchg] = k; nchg++;
            end
            prev = cnt_a;
            if (exp_a) begin nexp++; texp = k; end
        end
        chk("t1_nchg", 16'(nchg), 16'd3);
        for (int j = 0; j < 3; j++) begin
            chk("t1_val", 16'(chg_v[j]), 16'(2 - j));
            chk("t1_time", 16'(chg_t[j]), 16'(4 * (j + 1)));
        end
        chk("t1_nexp", 16'(nexp), 16'd1);
        chk("t1_texp", 16'(texp), 16'd13);
        chk("t1_done", {15'b0, done_a}, 16'd1);
        chk("t1_hold0", {12'b0, cnt_a}, 16'd0);
        cyc(1, 0, 0, 0, 4'd0);
        chk("t1_restart", {11'b0, cnt_a, run_a}, {11'b0, 4'd3, 1'b1});

        // Pause mid-period, resume from the frozen prescaler.
        cyc(0, 0, 1, 0, 4'd0);
        cyc(0, 0, 0, 1, 4'd9);
        cyc(1, 0, 0, 0, 4'd0);
        idle(10);
        chk("t2_pre", {12'b0, cnt_a}, 16'd7);
        cyc(0, 1, 0, 0, 4'd0);
        idle(10);
        chk("t2_hold", {11'b0, cnt_a, pau_a}, {11'b0, 4'd7, 1'b1});
        cyc(1, 0, 0, 0, 4'd0);
        hit = 0;
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 0, 0, 0, 4'd0);
            if (hit == 0 && cnt_a != 4'd7) hit = k;
        end
        chk("t2_resume", 16'(hit), 16'd2);

        // Start with count 0 goes straight to DONE.
        cyc(0, 0, 1, 0, 4'd0);
        cyc(0, 0, 0, 1, 4'd0);
        cyc(1, 0, 0, 0, 4'd0);
        chk("t3_done", {11'b0, cnt_a, done_a}, {11'b0, 4'd0, 1'b1});
        cyc(0, 0, 0, 0, 4'd0);
        chk("t3_exp", {15'b0, exp_a}, 16'd1);
        hit = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0, 0, 0, 4'd0);
            if (cnt_a == 4'hF || exp_a) hit++;
        end
        chk("t3_quiet", 16'(hit), 16'd0);

        // Auto-reload wraps on the N=2 instance.
        cyc(0, 0, 1, 0, 4'd0);
        cyc(0, 0, 0, 1, 4'd3);
        cyc(1, 0, 0, 0, 4'd0);
        nchg = 0; nexp = 0; bad_run = 0; prev = {2'b0, cnt_b};
        for (int k = 1; k <= 40; k++) begin
            cyc(0, 0, 0, 0, 4'd0);
            if ({2'b0, cnt_b} != prev && nchg < 8) begin
                chg_v[nchg] = int'(cnt_b); nchg++;
            end
            prev = {2'b0, cnt_b};
            if (exp_b) nexp++;
            if (!run_b) bad_run++;
        end
        chk("t4_seq", 16'({chg_v[0][3:0], chg_v[1][3:0], chg_v[2][3:0], chg_v[3][3:0]}), 16'h2103);
        chk("t4_nexp", 16'(nexp), 16'd2);
        chk("t4_run", 16'(bad_run), 16'd0);

        // clear beats start; load while running is dropped.
        cyc(0, 0, 1, 0, 4'd0);
        cyc(0, 0, 0, 1, 4'd5);
        cyc(1, 0, 0, 0, 4'd0);
        idle(3);
        cyc(0, 0, 0, 1, 4'd2);
        idle(2);
        cyc(1, 0, 1, 0, 4'd0);
        chk("t5_a", {11'b0, cnt_a, run_a}, {11'b0, 4'd5, 1'b0});
        chk("t5_b", {13'b0, cnt_b, run_b}, {13'b0, 2'd1, 1'b0});

        // Asynchronous reset mid-run, then fresh countdown from full scale.
        cyc(1, 0, 0, 0, 4'd0);
        idle(6);
        #3 reset = 1'b0;
        #1;
        chk("t6_rst_a", obs_a, 16'h00F0);
        chk("t6_rst_b", obs_b, 16'h0030);
        ma = mreset(4);
        mb = mreset(2);
        #2 reset = 1'b1;
        idle(1);
        cyc(1, 0, 0, 0, 4'd0);
        idle(4);
        chk("t6_count", {11'b0, cnt_a, run_a}, {11'b0, 4'd14, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
